// File: rtl/instr_encoder.sv
// MIPS instruction-word encoder with a small write FIFO in front of the instruction-memory port.
// Encoded words are buffered so the loader is never stalled directly by memory back-pressure.
module instr_encoder #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              finish,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        cls,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [5:0]        funct,
    input  logic [15:0]       imm,
    output logic              imem_valid,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              err_illegal,
    output logic              done,
    output logic              busy
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OCC_W = PTR_W + 1;
    localparam int unsigned CNT_W = ADDR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [2:0] CLS_R     = 3'd0;
    localparam logic [2:0] CLS_LW    = 3'd1;
    localparam logic [2:0] CLS_SW    = 3'd2;
    localparam logic [2:0] CLS_BEQ   = 3'd3;
    localparam logic [2:0] CLS_ORI   = 3'd4;
    localparam logic [2:0] CLS_JRSAL = 3'd5;
    localparam logic [2:0] CLS_BALN  = 3'd6;
    localparam logic [2:0] CLS_ILL   = 3'd7;

    logic [1:0]       state, state_n;
    logic [PTR_W-1:0] rd_idx, rd_n, wr_idx, wr_n;
    logic [OCC_W-1:0] occ, occ_n;
    logic [31:0]      mem [DEPTH];

    logic [5:0]        op;
    logic [31:0]       enc_word;
    logic              hs, push, pop;
    logic [ADDR_W-1:0] addr_n;
    logic [CNT_W-1:0]  count_n;
    logic              err_n;
    logic [31:0]       head_n;
    logic              in_ready_n, imem_valid_n, done_n, busy_n;

    // Field packing: R-format uses funct/shamt, every other class is op/rs/rt/imm.
    always_comb begin
        op = 6'b000000;
        case (cls)
            CLS_LW:    op = 6'b100011;
            CLS_SW:    op = 6'b101011;
            CLS_BEQ:   op = 6'b000100;
            CLS_ORI:   op = 6'b001101;
            CLS_JRSAL: op = 6'b010001;
            CLS_BALN:  op = 6'b011011;
            default:   op = 6'b000000;
        endcase
        if (cls == CLS_R) begin
            enc_word = {6'b000000, rs, rt, rd, shamt, funct};
        end else begin
            enc_word = {op, rs, rt, imm};
        end
    end

    // Next-state, FIFO bookkeeping and next values of the registered outputs.
    always_comb begin
        state_n = state;
        rd_n    = rd_idx;
        wr_n    = wr_idx;
        occ_n   = occ;
        addr_n  = imem_addr;
        count_n = count;
        err_n   = err_illegal;
        hs      = in_valid & in_ready;
        push    = hs & (cls != CLS_ILL);
        pop     = imem_valid & imem_ready;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_n = S_RUN;
                    addr_n  = base_addr;
                    count_n = '0;
                    err_n   = 1'b0;
                end
            end
            S_RUN: begin
                if (finish) begin
                    state_n = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (occ == '0) begin
                    state_n = S_DONE;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase

        if (hs && (cls == CLS_ILL)) begin
            err_n = 1'b1;
        end
        if (push) begin
            wr_n = wr_idx + PTR_W'(1);
        end
        if (pop) begin
            rd_n   = rd_idx + PTR_W'(1);
            addr_n = imem_addr + ADDR_W'(1);
            if (count != {CNT_W{1'b1}}) begin
                count_n = count + CNT_W'(1);
            end
        end
        case ({push, pop})
            2'b10:   occ_n = occ + OCC_W'(1);
            2'b01:   occ_n = occ - OCC_W'(1);
            default: occ_n = occ;
        endcase

        // Head after this edge; a word written into the head slot bypasses the array.
        if (occ_n == '0) begin
            head_n = imem_wdata;
        end else if (push && (wr_idx == rd_n)) begin
            head_n = enc_word;
        end else begin
            head_n = mem[rd_n];
        end

        in_ready_n   = (state_n == S_RUN) && (occ_n != OCC_W'(DEPTH));
        imem_valid_n = ((state_n == S_RUN) || (state_n == S_DRAIN)) && (occ_n != '0);
        done_n       = (state_n == S_DONE);
        busy_n       = (state_n != S_IDLE);
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rd_idx      <= '0;
            wr_idx      <= '0;
            occ         <= '0;
            in_ready    <= 1'b0;
            imem_valid  <= 1'b0;
            imem_addr   <= '0;
            imem_wdata  <= '0;
            count       <= '0;
            err_illegal <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            rd_idx      <= rd_n;
            wr_idx      <= wr_n;
            occ         <= occ_n;
            in_ready    <= in_ready_n;
            imem_valid  <= imem_valid_n;
            imem_addr   <= addr_n;
            imem_wdata  <= head_n;
            count       <= count_n;
            err_illegal <= err_n;
            done        <= done_n;
            busy        <= busy_n;
        end
    end

    // FIFO storage; occupancy tracking guarantees stale slots are never presented.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_idx] <= enc_word;
        end
    end

endmodule
